// File: rtl/colnorm_order_sched.sv
// Sorted-QR column-order sequencer: per stage, latch norms, scan k..NCOL-1 for the
// minimum norm, issue a k<->min swap and track the cumulative column permutation.
//
// state   | meaning
// IDLE    | waiting for start
// WAIT    | norm_rdy high, waiting for stage norms
// SCAN    | one column per cycle through the shared min compare
// ISSUE   | swap command held until swap_rdy
// DONE    | one-cycle completion pulse
`ifndef COLNORM_WL
`define COLNORM_WL 16
`endif

module colnorm_order_sched #(
   parameter int NCOL = 8,
   parameter int WL   = `COLNORM_WL
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   output logic                 busy,
   output logic                 done,
   input  logic [NCOL*WL-1:0]   norm_i,
   input  logic                 norm_vld,
   output logic                 norm_rdy,
   output logic                 swap_vld,
   input  logic                 swap_rdy,
   output logic [2:0]           swap_k,
   output logic [2:0]           swap_col,
   output logic [NCOL*3-1:0]    perm_o
);

   localparam logic [2:0] LAST_COL = 3'(NCOL - 1);
   localparam logic [2:0] LAST_K   = 3'(NCOL - 2);

   typedef enum logic [2:0] {S_IDLE, S_WAIT, S_SCAN, S_ISSUE, S_DONE} state_t;

   state_t          state_q, state_d;
   logic [2:0]      k_q, idx_q, ptr_q;
   logic [WL-1:0]   min_q;
   logic [WL-1:0]   norm_q [NCOL];
   logic [2:0]      perm_q [NCOL];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      busy     = (state_q != S_IDLE);
      done     = (state_q == S_DONE);
      norm_rdy = (state_q == S_WAIT);
      swap_vld = (state_q == S_ISSUE);
      swap_k   = k_q;
      swap_col = idx_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_WAIT;
         S_WAIT:  if (norm_vld) state_d = S_SCAN;
         S_SCAN:  if (ptr_q == LAST_COL) state_d = S_ISSUE;
         S_ISSUE: if (swap_rdy) state_d = (k_q == LAST_K) ? S_DONE : S_WAIT;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         k_q   <= '0;
         idx_q <= '0;
         ptr_q <= '0;
         min_q <= '0;
         for (int j = 0; j < NCOL; j++) begin
            norm_q[j] <= '0;
            perm_q[j] <= 3'(j);
         end
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  k_q <= '0;
                  for (int j = 0; j < NCOL; j++) perm_q[j] <= 3'(j);
               end
            end
            S_WAIT: begin
               if (norm_vld) begin
                  for (int j = 0; j < NCOL; j++) begin
                     norm_q[j] <= norm_i[j*WL +: WL];
                     if (3'(j) == k_q) min_q <= norm_i[j*WL +: WL];
                  end
                  idx_q <= k_q;
                  ptr_q <= k_q + 3'd1;
               end
            end
            S_SCAN: begin
               // strict compare: ascending scan keeps the lowest index on ties
               if (norm_q[ptr_q] < min_q) begin
                  min_q <= norm_q[ptr_q];
                  idx_q <= ptr_q;
               end
               ptr_q <= ptr_q + 3'd1;
            end
            S_ISSUE: begin
               if (swap_rdy) begin
                  perm_q[k_q]   <= perm_q[idx_q];
                  perm_q[idx_q] <= perm_q[k_q];
                  k_q           <= k_q + 3'd1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      perm_o = '0;
      for (int j = 0; j < NCOL; j++) perm_o[j*3 +: 3] = perm_q[j];
   end

endmodule

// File: tb/tb_colnorm_order_sched.sv
// Bench for colnorm_order_sched: run-level reference model compared every cycle,
// plus directed runs with hand-computed swap columns, latencies and permutations.
module tb_colnorm_order_sched;
   localparam int NCOL = 8;
   localparam int WL   = 16;
   localparam logic [23:0] ID_PERM = 24'hFAC688;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 start = 1'b0;
   logic                 busy, done, norm_rdy, swap_vld;
   logic [NCOL*WL-1:0]   norm_i = '0;
   logic                 norm_vld = 1'b0;
   logic                 swap_rdy = 1'b0;
   logic [2:0]           swap_k, swap_col;
   logic [NCOL*3-1:0]    perm_o;

   int n_tests = 0;
   int n_fail  = 0;
   int done_cnt = 0;
   bit chk_en = 1'b0;

   colnorm_order_sched #(.NCOL(NCOL), .WL(WL)) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
      .norm_i(norm_i), .norm_vld(norm_vld), .norm_rdy(norm_rdy),
      .swap_vld(swap_vld), .swap_rdy(swap_rdy), .swap_k(swap_k),
      .swap_col(swap_col), .perm_o(perm_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // reference model: phase 0 idle, 1 awaiting norms, 2 selecting, 3 swap offered, 4 done
   int         m_phase, m_k, m_cnt, m_col;
   logic [2:0] m_perm [NCOL];

   function automatic int argmin_from(input logic [NCOL*WL-1:0] v, input int k);
      int best = k;
      for (int j = k + 1; j < NCOL; j++)
         if (v[j*WL +: WL] < v[best*WL +: WL]) best = j;
      return best;
   endfunction

   function automatic logic [23:0] pack_perm();
      logic [23:0] r = '0;
      for (int j = 0; j < NCOL; j++) r[j*3 +: 3] = m_perm[j];
      return r;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_phase <= 0; m_k <= 0; m_cnt <= 0; m_col <= 0;
         for (int j = 0; j < NCOL; j++) m_perm[j] <= 3'(j);
      end else begin
         case (m_phase)
            0: if (start) begin
                  m_phase <= 1; m_k <= 0;
                  for (int j = 0; j < NCOL; j++) m_perm[j] <= 3'(j);
               end
            1: if (norm_vld) begin
                  m_col <= argmin_from(norm_i, m_k);
                  m_cnt <= NCOL - m_k - 1;
                  m_phase <= 2;
               end
            2: begin
                  m_cnt <= m_cnt - 1;
                  if (m_cnt == 1) m_phase <= 3;
               end
            3: if (swap_rdy) begin
                  m_perm[m_k]   <= m_perm[m_col];
                  m_perm[m_col] <= m_perm[m_k];
                  m_k <= m_k + 1;
                  m_phase <= (m_k + 1 == NCOL - 1) ? 4 : 1;
               end
            default: m_phase <= 0;
         endcase
      end
   end

   always @(negedge clk) begin
      if (!rst && chk_en) begin
         chk("busy", busy, 64'(m_phase != 0));
         chk("done", done, 64'(m_phase == 4));
         chk("norm_rdy", norm_rdy, 64'(m_phase == 1));
         chk("swap_vld", swap_vld, 64'(m_phase == 3));
         if (m_phase == 3) begin
            chk("swap_k", swap_k, 64'(m_k));
            chk("swap_col", swap_col, 64'(m_col));
         end
         chk("perm", perm_o, pack_perm());
         if (done) done_cnt++;
      end
   end

   function automatic logic [NCOL*WL-1:0] asc();
      logic [NCOL*WL-1:0] r;
      for (int j = 0; j < NCOL; j++) r[j*WL +: WL] = WL'(j + 1);
      return r;
   endfunction

   function automatic logic [NCOL*WL-1:0] flat(input int base, input int j1, input int v1,
                                                input int j2, input int v2);
      logic [NCOL*WL-1:0] r;
      for (int j = 0; j < NCOL; j++) r[j*WL +: WL] = WL'(base);
      if (j1 >= 0) r[j1*WL +: WL] = WL'(v1);
      if (j2 >= 0) r[j2*WL +: WL] = WL'(v2);
      return r;
   endfunction

   task automatic do_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_norm_rdy();
      int n = 0;
      @(negedge clk);
      while (!norm_rdy && n < 50) begin @(negedge clk); n++; end
      chk("norm_rdy_wait", norm_rdy, 1);
   endtask

   task automatic feed(input logic [NCOL*WL-1:0] v);
      wait_norm_rdy();
      norm_i = v; norm_vld = 1'b1;
      @(posedge clk); #1;
      norm_vld = 1'b0;
      norm_i = '1;
   endtask

   task automatic run_stage(input logic [NCOL*WL-1:0] v, input int hold, input int exp_k,
                            input int exp_col, input logic [23:0] hold_perm, output int lat);
      lat = 0;
      feed(v);
      do begin @(negedge clk); lat++; end while (!swap_vld && lat < 50);
      chk("swap_vld_wait", swap_vld, 1);
      chk("stage_k", swap_k, 64'(exp_k));
      chk("stage_col", swap_col, 64'(exp_col));
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("hold_vld", swap_vld, 1);
         chk("hold_k", swap_k, 64'(exp_k));
         chk("hold_col", swap_col, 64'(exp_col));
         chk("hold_perm", perm_o, 64'(hold_perm));
      end
      swap_rdy = 1'b1;
      @(posedge clk); #1;
      swap_rdy = 1'b0;
   endtask

   task automatic wait_done(input bit pulse_start);
      int n = 0;
      @(negedge clk);
      while (!done && n < 50) begin @(negedge clk); n++; end
      chk("done_seen", done, 1);
      if (pulse_start) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      chk("busy_after_done", busy, 0);
   endtask

   initial begin
      int lat, d0;
      #22 rst = 1'b0;
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_norm_rdy", norm_rdy, 0);
      chk("rst_swap_vld", swap_vld, 0);
      chk("rst_swap_k", swap_k, 0);
      chk("rst_swap_col", swap_col, 0);
      chk("rst_perm", perm_o, 64'(ID_PERM));
      chk_en = 1'b1;
      @(posedge clk); #1;

      // ascending norms: every stage selects its own column
      d0 = done_cnt;
      do_start();
      for (int s = 0; s < NCOL - 1; s++) begin
         run_stage(asc(), 0, s, s, 24'h0, lat);
         chk("t1_latency", lat, 64'(NCOL - s));
      end
      wait_done(1'b0);
      chk("t1_perm_identity", perm_o, 64'(ID_PERM));
      repeat (3) @(negedge clk);
      chk("t1_done_pulses", done_cnt - d0, 1);

      // single small norm at column 5 in stage 0
      d0 = done_cnt;
      do_start();
      run_stage(flat(10, 5, 3, -1, 0), 0, 0, 5, 24'h0, lat);
      chk("t2_latency", lat, 8);
      chk("t2_model_col", m_col, 5);
      chk("t2_perm0", perm_o[2:0], 5);
      chk("t2_perm5", perm_o[17:15], 0);
      for (int s = 1; s < NCOL - 1; s++) run_stage(asc(), 0, s, s, 24'h0, lat);
      wait_done(1'b0);
      chk("t2_final_perm", perm_o, 64'(24'hF8468D));
      chk("t2_done_pulses", done_cnt - d0, 1);

      // tie at stage 2, swap held off, start pulsed in WAIT_NORM and DONE
      d0 = done_cnt;
      do_start();
      wait_norm_rdy();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      run_stage(asc(), 0, 0, 0, 24'h0, lat);
      run_stage(asc(), 0, 1, 1, 24'h0, lat);
      run_stage(flat(9, 3, 4, 6, 4), 3, 2, 3, ID_PERM, lat);
      chk("t3_perm2", perm_o[8:6], 3);
      chk("t3_perm3", perm_o[11:9], 2);
      for (int s = 3; s < NCOL - 1; s++) run_stage(asc(), 0, s, s, 24'h0, lat);
      wait_done(1'b1);
      repeat (4) @(negedge clk);
      chk("t6_idle_busy", busy, 0);
      chk("t6_idle_norm_rdy", norm_rdy, 0);
      chk("t6_done_pulses", done_cnt - d0, 1);

      // reset during stage 3 scan aborts the run
      @(posedge clk); #1;
      do_start();
      run_stage(flat(10, 4, 2, -1, 0), 0, 0, 4, 24'h0, lat);
      run_stage(asc(), 0, 1, 1, 24'h0, lat);
      run_stage(asc(), 0, 2, 2, 24'h0, lat);
      feed(asc());
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      chk("t5_busy", busy, 0);
      chk("t5_done", done, 0);
      chk("t5_norm_rdy", norm_rdy, 0);
      chk("t5_swap_vld", swap_vld, 0);
      chk("t5_swap_k", swap_k, 0);
      chk("t5_swap_col", swap_col, 0);
      chk("t5_perm", perm_o, 64'(ID_PERM));
      @(negedge clk); #3;
      rst = 1'b0;
      @(posedge clk); #1;
      d0 = done_cnt;
      do_start();
      run_stage(flat(10, 2, 1, -1, 0), 0, 0, 2, 24'h0, lat);
      chk("t5_restart_latency", lat, 8);
      chk("t5_restart_perm0", perm_o[2:0], 2);
      for (int s = 1; s < NCOL - 1; s++) run_stage(asc(), 0, s, s, 24'h0, lat);
      wait_done(1'b0);
      chk("t5_done_pulses", done_cnt - d0, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: run did not finish, %0d failed so far", n_fail);
      $fatal(1, "watchdog");
   end

endmodule
